// File: rtl/bumpy_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bumpy_pkg
//  Purpose : Shared definitions for the Bumpy sprite blocks: FSM state codes,
//            tile type codes, edge orientation codes and a saturating
//            gravity helper used by the movement stage.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package bumpy_pkg;

  // FSM state codes, shared with the Bumpy control FSM
  localparam int STATE_W = 4;
  localparam logic [3:0] Sreset = 4'd0;
  localparam logic [3:0] Sidle  = 4'd1;
  localparam logic [3:0] Sleft  = 4'd2;
  localparam logic [3:0] Sright = 4'd3;
  localparam logic [3:0] Sdown  = 4'd4;
  localparam logic [3:0] Sup    = 4'd5;
  localparam logic [3:0] Sdie   = 4'd6;

  // Tile type codes reported by the collision logic
  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;
  localparam logic [2:0] TILE_SPIKE = 3'd2;
  localparam logic [2:0] TILE_GIFT  = 3'd3;
  localparam logic [2:0] TILE_EXIT  = 3'd4;

  // Edge orientation codes (which side of the sprite touched a tile)
  localparam logic [2:0] EDGE_NONE   = 3'd0;
  localparam logic [2:0] EDGE_TOP    = 3'd1;
  localparam logic [2:0] EDGE_BOTTOM = 3'd2;
  localparam logic [2:0] EDGE_LEFT   = 3'd3;
  localparam logic [2:0] EDGE_RIGHT  = 3'd4;

  // Width of the signed fixed-point speed values
  localparam int SPEED_W = 11;

  // Adds one gravity step to a vertical speed and saturates at vmax.
  // The sum is formed one bit wider so it can never wrap.
  function automatic logic signed [SPEED_W-1:0] fall_speed(
    input logic signed [SPEED_W-1:0] spd,
    input logic signed [SPEED_W-1:0] grav,
    input logic signed [SPEED_W-1:0] vmax
  );
    logic signed [SPEED_W:0] sum;
    sum = $signed({spd[SPEED_W-1], spd}) + $signed({grav[SPEED_W-1], grav});
    if (sum > $signed({vmax[SPEED_W-1], vmax})) begin
      fall_speed = vmax;
    end else begin
      fall_speed = sum[SPEED_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bumpy_axis.sv
`default_nettype none
// ============================================================================
//  Module  : bumpy_axis
//  Purpose : Single-axis fixed-point integrator. Once per frame adds the
//            supplied speed to the position register, clamps the result to
//            [0, MAX_PX] pixels and reports whether the clamp engaged.
//            The integer pixel coordinate is the floor of the position.
//  Ports   : clk          system clock
//            resetN       asynchronous active-low reset
//            startOfFrame update strobe, one cycle per frame
//            load         reload the initial position on this frame
//            speed        signed fixed-point speed applied this frame
//            clamped      combinational: this frame's sum left the range
//            topLeft      signed integer pixel coordinate (registered)
//  Rev     : 1.0  initial release
// ============================================================================
module bumpy_axis
  import bumpy_pkg::*;
#(
  parameter int FRAC_BITS = 6,
  parameter int INIT_PX   = 280,
  parameter int MAX_PX    = 608
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      load,
  input  logic signed [SPEED_W-1:0] speed,
  output logic                      clamped,
  output logic signed [10:0]        topLeft
);

  localparam int POS_W = 11 + FRAC_BITS;
  localparam logic signed [POS_W-1:0] c_INIT_POS = POS_W'(INIT_PX * (2 ** FRAC_BITS));
  localparam logic signed [POS_W:0]   c_MAX_POS  = (POS_W + 1)'(MAX_PX * (2 ** FRAC_BITS));

  logic signed [POS_W-1:0] r_pos;
  logic signed [POS_W:0]   w_sum;
  logic signed [POS_W:0]   w_speed_ext;
  logic signed [POS_W-1:0] w_pos_nxt;

  // One extra bit of headroom so an overshoot past either edge is visible
  // as a sign or magnitude excess rather than a wrap.
  assign w_speed_ext = {{(POS_W + 1 - SPEED_W){speed[SPEED_W-1]}}, speed};
  assign w_sum       = {r_pos[POS_W-1], r_pos} + w_speed_ext;

  always_comb begin
    w_pos_nxt = w_sum[POS_W-1:0];
    clamped   = 1'b0;
    if (w_sum[POS_W]) begin
      w_pos_nxt = '0;
      clamped   = 1'b1;
    end else if (w_sum > c_MAX_POS) begin
      w_pos_nxt = c_MAX_POS[POS_W-1:0];
      clamped   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pos <= c_INIT_POS;
    end else if (startOfFrame) begin
      if (load) begin
        r_pos <= c_INIT_POS;
      end else begin
        r_pos <= w_pos_nxt;
      end
    end
  end

  // Dropping the fraction bits of a two's-complement value is a floor.
  assign topLeft = r_pos[POS_W-1:FRAC_BITS];

endmodule
`default_nettype wire

// File: rtl/bumpy_motion.sv
`default_nettype none
// ============================================================================
//  Module  : bumpy_motion
//  Purpose : Movement stage behind the Bumpy control FSM. Once per video
//            frame selects X/Y speeds from the FSM state, integrates them
//            into clamped fixed-point positions and blinks the sprite while
//            dead.
//  Ports   : clk          system clock
//            resetN       asynchronous active-low reset
//            startOfFrame one-cycle pulse per video frame
//            state        4-bit FSM state code (bumpy_pkg encoding)
//            die          sticky death flag from the FSM
//            topLeftX     signed sprite top-left X, integer px
//            topLeftY     signed sprite top-left Y, integer px
//            visible      sprite draw enable
//  Rev     : 1.0  initial release
// ============================================================================
module bumpy_motion
  import bumpy_pkg::*;
#(
  parameter int FRAC_BITS    = 6,
  parameter int INIT_X       = 280,
  parameter int INIT_Y       = 185,
  parameter int X_SPEED      = 128,
  parameter int UP_SPEED     = 192,
  parameter int GRAVITY      = 8,
  parameter int MAX_Y_SPEED  = 256,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int OBJ_W        = 32,
  parameter int OBJ_H        = 32,
  parameter int BLINK_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [3:0]         state,
  input  logic               die,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               visible
);

  localparam logic signed [SPEED_W-1:0] c_X_SPEED   = SPEED_W'(X_SPEED);
  localparam logic signed [SPEED_W-1:0] c_UP_SPEED  = SPEED_W'(UP_SPEED);
  localparam logic signed [SPEED_W-1:0] c_GRAVITY   = SPEED_W'(GRAVITY);
  localparam logic signed [SPEED_W-1:0] c_MAX_Y_SPD = SPEED_W'(MAX_Y_SPEED);
  localparam int c_BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_FRAMES - 1);

  logic signed [SPEED_W-1:0] r_speed_x;
  logic signed [SPEED_W-1:0] r_speed_y;
  logic [3:0]                r_prev_state;
  logic [c_BLINK_W-1:0]      r_blink_cnt;
  logic                      r_visible;

  logic [3:0]                w_eff_state;
  logic signed [SPEED_W-1:0] w_speed_x_nxt;
  logic signed [SPEED_W-1:0] w_speed_y_nxt;
  logic                      w_load;
  logic                      w_horiz;
  logic                      w_clamp_x;
  logic                      w_clamp_y;

  // Death overrides whatever the FSM reports; unknown codes behave as idle.
  always_comb begin
    w_eff_state = Sidle;
    if (die) begin
      w_eff_state = Sdie;
    end else begin
      case (state)
        Sreset, Sidle, Sleft, Sright, Sdown, Sup, Sdie: w_eff_state = state;
        default:                                        w_eff_state = Sidle;
      endcase
    end
  end

  // Speed selection. The axes add these new speeds on the same frame.
  always_comb begin
    w_speed_x_nxt = '0;
    w_speed_y_nxt = '0;
    w_load        = 1'b0;
    w_horiz       = 1'b0;
    case (w_eff_state)
      Sreset: begin
        w_load = 1'b1;
      end
      Sleft, Sright: begin
        w_horiz       = 1'b1;
        w_speed_x_nxt = (w_eff_state == Sleft) ? -c_X_SPEED : c_X_SPEED;
        // Leaving a jump cancels the upward momentum instead of decaying it.
        if (r_prev_state == Sup) begin
          w_speed_y_nxt = '0;
        end else begin
          w_speed_y_nxt = fall_speed(r_speed_y, c_GRAVITY, c_MAX_Y_SPD);
        end
      end
      Sdown: begin
        if (r_prev_state != Sdown) begin
          w_speed_y_nxt = c_GRAVITY;
        end else begin
          w_speed_y_nxt = fall_speed(r_speed_y, c_GRAVITY, c_MAX_Y_SPD);
        end
      end
      Sup: begin
        w_speed_y_nxt = -c_UP_SPEED;
      end
      default: begin
        // Sidle and Sdie: stand still
      end
    endcase
  end

  bumpy_axis #(
    .FRAC_BITS (FRAC_BITS),
    .INIT_PX   (INIT_X),
    .MAX_PX    (SCREEN_W - OBJ_W)
  ) u_axis_x (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .load         (w_load),
    .speed        (w_speed_x_nxt),
    .clamped      (w_clamp_x),
    .topLeft      (topLeftX)
  );

  bumpy_axis #(
    .FRAC_BITS (FRAC_BITS),
    .INIT_PX   (INIT_Y),
    .MAX_PX    (SCREEN_H - OBJ_H)
  ) u_axis_y (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .load         (w_load),
    .speed        (w_speed_y_nxt),
    .clamped      (w_clamp_y),
    .topLeft      (topLeftY)
  );

  // A clamp kills the speed on that axis, except horizontal walking keeps
  // its X speed so the FSM can still see the direction of travel.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_speed_x    <= '0;
      r_speed_y    <= '0;
      r_prev_state <= Sreset;
    end else if (startOfFrame) begin
      r_speed_x    <= (w_clamp_x && !w_horiz) ? '0 : w_speed_x_nxt;
      r_speed_y    <= w_clamp_y ? '0 : w_speed_y_nxt;
      r_prev_state <= state;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else if (startOfFrame) begin
      if (w_eff_state == Sdie) begin
        if (r_blink_cnt == c_BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_visible   <= ~r_visible;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
      end else begin
        r_blink_cnt <= '0;
        r_visible   <= 1'b1;
      end
    end
  end

  // A live sprite is always drawn, independent of the blink phase.
  assign visible = r_visible | ~die;

endmodule
`default_nettype wire

// File: tb/tb_bumpy_motion.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bumpy_motion
//  Purpose : Self-checking bench for bumpy_motion. Directed vector table of
//            {reset, state, die, frame count} with hand-computed expected
//            sprite coordinates and visibility, plus hand-written sequences
//            for frame-less holding, blinking and mid-frame reset.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_bumpy_motion;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_LEFT  = 4'd2;
  localparam logic [3:0] S_RIGHT = 4'd3;
  localparam logic [3:0] S_DOWN  = 4'd4;
  localparam logic [3:0] S_UP    = 4'd5;
  localparam logic [3:0] S_DIE   = 4'd6;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic [3:0]         state;
  logic               die;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               visible;

  int n_checks;
  int n_fail;

  typedef struct {
    bit       rst;
    bit [3:0] st;
    bit       dd;
    int       frames;
    int       ex;
    int       ey;
    int       ev;
  } vec_t;

  vec_t vq[$];

  bumpy_motion dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .state        (state),
    .die          (die),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .visible      (visible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input int ex, input int ey, input int ev);
    check({nm, "_x"}, int'(topLeftX), ex);
    check({nm, "_y"}, int'(topLeftY), ey);
    check({nm, "_vis"}, int'(visible), ev);
  endtask

  task automatic add(input bit rst, input bit [3:0] st, input bit dd, input int frames,
                     input int ex, input int ey, input int ev);
    vec_t v;
    v.rst = rst; v.st = st; v.dd = dd; v.frames = frames;
    v.ex = ex; v.ey = ey; v.ev = ev;
    vq.push_back(v);
  endtask

  // Inputs change on the falling edge; the rising edge samples them.
  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    state        = S_IDLE;
    die          = 1'b0;

    //  rst state    die frames  X    Y    vis
    add(1, S_IDLE,  0, 5,   280, 185, 1);
    add(0, S_RIGHT, 0, 10,  300, 191, 1);  // Y falls: sum 8..80 = 440
    add(0, S_LEFT,  0, 5,   290, 200, 1);  // Y: +88..120 = 520
    add(0, S_RESET, 0, 1,   280, 185, 1);
    add(0, 4'd9,    0, 8,   280, 185, 1);  // unknown code stands still
    add(1, S_DOWN,  0, 4,   280, 186, 1);  // 8+16+24+32 = 80
    add(0, S_DOWN,  0, 28,  280, 251, 1);  // 32 frames: 4224
    add(0, S_DOWN,  0, 4,   280, 267, 1);  // capped at 256/frame
    add(1, S_UP,    0, 5,   280, 170, 1);
    add(0, S_LEFT,  0, 1,   278, 170, 1);  // leaving Sup: speedY 0
    add(0, S_UP,    0, 56,  278, 2,   1);
    add(0, S_UP,    0, 1,   278, 0,   1);  // clamp at top
    add(0, S_UP,    0, 3,   278, 0,   1);
    add(1, S_LEFT,  0, 139, 2,   448, 1);  // Y reaches bottom clamp
    add(0, S_LEFT,  0, 2,   0,   448, 1);  // clamp at left
    add(0, S_RIGHT, 0, 1,   2,   448, 1);
    add(0, S_DIE,   1, 7,   2,   448, 1);
    add(0, S_DIE,   1, 1,   2,   448, 0);  // 8th frame toggles
    add(0, S_DIE,   1, 8,   2,   448, 1);
    add(0, S_DIE,   1, 4,   2,   448, 1);
    add(0, S_RIGHT, 1, 4,   2,   448, 0);  // die overrides state
    add(0, S_IDLE,  0, 1,   2,   448, 1);

    repeat (3) @(negedge clk);
    check_out("reset_hold", 280, 185, 1);
    resetN = 1'b1;
    @(negedge clk);
    check_out("reset_release", 280, 185, 1);

    for (int i = 0; i < vq.size(); i++) begin
      state = vq[i].st;
      die   = vq[i].dd;
      if (vq[i].rst) do_reset();
      for (int f = 0; f < vq[i].frames; f++) frame();
      check_out($sformatf("vec%0d", i), vq[i].ex, vq[i].ey, vq[i].ev);
    end

    // No frame strobe: state wiggles must not move anything.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      state = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    check_out("no_frame_hold", 2, 448, 1);

    // Die for one blink period, then pull reset between clock edges.
    state = S_DIE;
    die   = 1'b1;
    for (int f = 0; f < 8; f++) frame();
    check_out("die_blink", 2, 448, 0);
    @(posedge clk);
    #2 resetN = 1'b0;
    #1 check_out("mid_frame_reset", 280, 185, 1);
    @(negedge clk);
    die    = 1'b0;
    state  = S_IDLE;
    resetN = 1'b1;
    frame();
    check_out("after_reset", 280, 185, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
